// File: rtl/if_stage_if.sv
// Instruction-memory request/response port used by the fetch stage.
// The master side issues requests; the slave side accepts them and returns in-order responses.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, valid, rdata);
    modport slave  (input req, addr, output ready, valid, rdata);
endinterface

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, keeps at most one request in flight and loads the IF/ID register.
// Responses that arrive after a redirect are drained; a one-entry buffer covers stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        PCSel,
    input  logic [31:0] br_target,
    input  logic        flush_ID,
    if_stage_if.master  imem,
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic        valid_ID
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_pend;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] target;
    logic        accept;
    logic        load_resp;
    logic        load_hold;

    assign target = {br_target[31:2], 2'b00};

    // WAIT only chains a new request when the current response is consumed this cycle.
    assign imem.req  = (state == FETCH) |
                       ((state == WAIT) & imem.valid & ~stall & ~PCSel);
    assign imem.addr = pc;
    assign accept    = imem.req & imem.ready;

    assign load_resp = (state == WAIT) & imem.valid & ~stall & ~PCSel & ~flush_ID;
    assign load_hold = (state == HOLD) & ~stall & ~PCSel & ~flush_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pc_pend    <= RESET_PC;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            if (PCSel)
                pc <= target;
            else if (accept)
                pc <= pc + 32'd4;

            if (accept)
                pc_pend <= pc;

            case (state)
                FETCH: begin
                    if (accept)
                        state <= PCSel ? DISCARD : WAIT;
                end
                WAIT: begin
                    if (imem.valid) begin
                        if (PCSel) begin
                            state <= FETCH;
                        end else if (stall) begin
                            hold_instr <= imem.rdata;
                            hold_pc    <= pc_pend;
                            state      <= HOLD;
                        end else begin
                            state <= accept ? WAIT : FETCH;
                        end
                    end else if (PCSel) begin
                        state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (PCSel || !stall)
                        state <= FETCH;
                end
                DISCARD: begin
                    if (imem.valid)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Flush wins even under stall; a response dropped by flush or redirect never reaches IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ID <= NOP_INSTR;
            pc_ID    <= RESET_PC;
            valid_ID <= 1'b0;
        end else if (flush_ID) begin
            instr_ID <= NOP_INSTR;
            valid_ID <= 1'b0;
        end else if (!stall) begin
            if (load_resp) begin
                instr_ID <= imem.rdata;
                pc_ID    <= pc_pend;
                valid_ID <= 1'b1;
            end else if (load_hold) begin
                instr_ID <= hold_instr;
                pc_ID    <= hold_pc;
                valid_ID <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns 0xC0DE0000+addr after a configurable latency.
// Inputs change and outputs are checked on the falling edge.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        PCSel;
    logic [31:0] br_target;
    logic        flush_ID;
    logic [31:0] instr_ID;
    logic [31:0] pc_ID;
    logic        valid_ID;

    int unsigned checks = 0;
    int unsigned errors = 0;

    if_stage_if imem ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .PCSel    (PCSel),
        .br_target(br_target),
        .flush_ID (flush_ID),
        .imem     (imem),
        .instr_ID (instr_ID),
        .pc_ID    (pc_ID),
        .valid_ID (valid_ID)
    );

    always #5 clk = ~clk;

    // Single-outstanding memory: response valid for one cycle, mem_lat cycles after acceptance.
    int unsigned mem_lat = 1;
    int unsigned m_cnt   = 0;
    logic        m_busy  = 1'b0;
    logic        m_acc;
    logic [31:0] m_sampled;
    logic [31:0] m_addr  = '0;

    initial begin
        imem.ready = 1'b1;
        imem.valid = 1'b0;
        imem.rdata = '0;
    end

    always @(posedge clk) begin
        m_acc     = imem.req & imem.ready;
        m_sampled = imem.addr;
        #1;
        if (!rst_n) begin
            imem.valid = 1'b0;
            m_busy     = 1'b0;
            m_cnt      = 0;
        end else begin
            if (imem.valid) imem.valid = 1'b0;
            if (m_acc) begin
                m_busy = 1'b1;
                m_addr = m_sampled;
                m_cnt  = mem_lat;
            end
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy     = 1'b0;
                    imem.valid = 1'b1;
                    imem.rdata = 32'hC0DE_0000 + m_addr;
                end
            end
        end
    end

    task automatic do_reset(input int unsigned lat);
        rst_n     = 1'b0;
        stall     = 1'b0;
        PCSel     = 1'b0;
        flush_ID  = 1'b0;
        br_target = '0;
        mem_lat   = lat;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; PCSel = 1'b0; flush_ID = 1'b0; br_target = '0; mem_lat = 1;
        repeat (2) @(negedge clk);
        checks++; if (instr_ID !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp %h", instr_ID, 32'h13); end
        checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_ID); end
        checks++; if (pc_ID !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_ID); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL c0_req got %b/%h exp 1/0", imem.req, imem.addr); end
        @(negedge clk);
        checks++; if (imem.addr !== 32'h4) begin errors++; $display("FAIL c1_addr got %h exp 4", imem.addr); end
        checks++; if (valid_ID !== 1'b0 || instr_ID !== 32'h13) begin errors++; $display("FAIL c1_id got %b/%h exp 0/13", valid_ID, instr_ID); end
        @(negedge clk);
        checks++; if (imem.addr !== 32'h8) begin errors++; $display("FAIL c2_addr got %h exp 8", imem.addr); end
        checks++; if (valid_ID !== 1'b1 || pc_ID !== 32'h0 || instr_ID !== 32'hC0DE_0000) begin errors++; $display("FAIL c2_id got %b/%h/%h exp 1/0/c0de0000", valid_ID, pc_ID, instr_ID); end
        @(negedge clk);
        checks++; if (imem.addr !== 32'hC || pc_ID !== 32'h4) begin errors++; $display("FAIL c3 got addr %h pc %h exp c/4", imem.addr, pc_ID); end
        @(negedge clk);
        checks++; if (pc_ID !== 32'h8 || instr_ID !== 32'hC0DE_0008) begin errors++; $display("FAIL c4 got %h/%h exp 8/c0de0008", pc_ID, instr_ID); end
    endtask

    task automatic test_stall_hold();
        do_reset(1);
        repeat (3) @(negedge clk);
        checks++; if (pc_ID !== 32'h4) begin errors++; $display("FAIL st_pre got %h exp 4", pc_ID); end
        stall = 1'b1;
        @(negedge clk);
        checks++; if (imem.req !== 1'b0 || pc_ID !== 32'h4 || valid_ID !== 1'b1) begin errors++; $display("FAIL st_hold got req %b pc %h v %b exp 0/4/1", imem.req, pc_ID, valid_ID); end
        repeat (2) @(negedge clk);
        checks++; if (pc_ID !== 32'h4 || instr_ID !== 32'hC0DE_0004) begin errors++; $display("FAIL st_end got %h/%h exp 4/c0de0004", pc_ID, instr_ID); end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (pc_ID !== 32'h8 || instr_ID !== 32'hC0DE_0008) begin errors++; $display("FAIL st_rel got %h/%h exp 8/c0de0008", pc_ID, instr_ID); end
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'hC) begin errors++; $display("FAIL st_req got %b/%h exp 1/c", imem.req, imem.addr); end
        @(negedge clk);
        checks++; if (pc_ID !== 32'h8) begin errors++; $display("FAIL st_next got %h exp 8", pc_ID); end
        @(negedge clk);
        checks++; if (pc_ID !== 32'hC || instr_ID !== 32'hC0DE_000C) begin errors++; $display("FAIL st_c got %h/%h exp c/c0de000c", pc_ID, instr_ID); end
    endtask

    task automatic test_redirect_wait();
        do_reset(3);
        repeat (4) @(negedge clk);
        checks++; if (pc_ID !== 32'h0 || valid_ID !== 1'b1) begin errors++; $display("FAIL rw_first got %h/%b exp 0/1", pc_ID, valid_ID); end
        PCSel = 1'b1; br_target = 32'h0000_0103;
        @(negedge clk);
        checks++; if (imem.req !== 1'b0 || imem.addr !== 32'h100) begin errors++; $display("FAIL rw_disc got %b/%h exp 0/100", imem.req, imem.addr); end
        PCSel = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h100 || pc_ID !== 32'h0) begin errors++; $display("FAIL rw_req got %b/%h pc %h exp 1/100/0", imem.req, imem.addr, pc_ID); end
        repeat (3) @(negedge clk);
        checks++; if (pc_ID !== 32'h0) begin errors++; $display("FAIL rw_stale got %h exp 0", pc_ID); end
        @(negedge clk);
        checks++; if (pc_ID !== 32'h100 || instr_ID !== 32'hC0DE_0100 || valid_ID !== 1'b1) begin errors++; $display("FAIL rw_tgt got %h/%h/%b exp 100/c0de0100/1", pc_ID, instr_ID, valid_ID); end
    endtask

    task automatic test_redirect_valid();
        do_reset(1);
        repeat (2) @(negedge clk);
        PCSel = 1'b1; br_target = 32'h0000_0200;
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin errors++; $display("FAIL rv_req got %b/%h exp 1/200", imem.req, imem.addr); end
        checks++; if (pc_ID !== 32'h0 || valid_ID !== 1'b1 || instr_ID !== 32'hC0DE_0000) begin errors++; $display("FAIL rv_drop got %h/%b/%h exp 0/1/c0de0000", pc_ID, valid_ID, instr_ID); end
        PCSel = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pc_ID !== 32'h200 || instr_ID !== 32'hC0DE_0200) begin errors++; $display("FAIL rv_tgt got %h/%h exp 200/c0de0200", pc_ID, instr_ID); end
    endtask

    task automatic test_flush_stall();
        do_reset(1);
        repeat (3) @(negedge clk);
        flush_ID = 1'b1; stall = 1'b1;
        @(negedge clk);
        checks++; if (instr_ID !== 32'h13 || valid_ID !== 1'b0 || pc_ID !== 32'h4) begin errors++; $display("FAIL fs_flush got %h/%b/%h exp 13/0/4", instr_ID, valid_ID, pc_ID); end
        flush_ID = 1'b0; stall = 1'b0;
        @(negedge clk);
        checks++; if (pc_ID !== 32'h8 || valid_ID !== 1'b1 || instr_ID !== 32'hC0DE_0008) begin errors++; $display("FAIL fs_rel got %h/%b/%h exp 8/1/c0de0008", pc_ID, valid_ID, instr_ID); end
    endtask

    task automatic test_fetch_redirect_wrap();
        do_reset(1);
        PCSel = 1'b1; br_target = 32'hFFFF_FFFE;
        @(negedge clk);
        checks++; if (imem.req !== 1'b0 || imem.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL fw_disc got %b/%h exp 0/fffffffc", imem.req, imem.addr); end
        PCSel = 1'b0;
        @(negedge clk);
        checks++; if (imem.req !== 1'b1 || valid_ID !== 1'b0) begin errors++; $display("FAIL fw_req got %b/%b exp 1/0", imem.req, valid_ID); end
        @(negedge clk);
        checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL fw_wrap got %h exp 0", imem.addr); end
        @(negedge clk);
        checks++; if (pc_ID !== 32'hFFFF_FFFC || instr_ID !== 32'hC0DD_FFFC || valid_ID !== 1'b1) begin errors++; $display("FAIL fw_id got %h/%h/%b exp fffffffc/c0ddfffc/1", pc_ID, instr_ID, valid_ID); end
    endtask

    task automatic test_async_reset();
        do_reset(1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc_ID !== 32'h0 || valid_ID !== 1'b0 || instr_ID !== 32'h13 || imem.addr !== 32'h0) begin errors++; $display("FAIL ar_now got %h/%b/%h addr %h exp 0/0/13/0", pc_ID, valid_ID, instr_ID, imem.addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL ar_rel got %b/%h exp 1/0", imem.req, imem.addr); end
        repeat (2) @(negedge clk);
        checks++; if (pc_ID !== 32'h0 || valid_ID !== 1'b1 || instr_ID !== 32'hC0DE_0000) begin errors++; $display("FAIL ar_first got %h/%b/%h exp 0/1/c0de0000", pc_ID, valid_ID, instr_ID); end
    endtask

    initial begin
        test_reset();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_valid();
        test_flush_stall();
        test_fetch_redirect_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the Fast_RV32I core: owns the program counter, drives the instruction-memory request port, and loads the IF/ID pipeline register consumed by the control-path decoder. It takes a redirect (`PCSel`, `br_target`) and a flush (`flush_ID`) back from the decode/branch logic and a `stall` from the hazard logic. At most one memory request is outstanding. Stale responses after a redirect are discarded, and a one-entry hold buffer absorbs a response that arrives while the pipeline is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction word placed in IF/ID on reset and on flush (addi x0,x0,0).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the IF/ID register and block new fetches.
- `PCSel`  in  1  redirect: take `br_target` as the next fetch PC.
- `br_target`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `flush_ID`  in  1  clear the IF/ID register to a bubble.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  request accepted when `imem_req & imem_ready`.
- `imem_valid`  in  1  response valid; in order, at least 1 cycle after acceptance.
- `imem_rdata`  in  32  response instruction word.
- `instr_ID`  out  32  IF/ID instruction to the decoder.
- `pc_ID`  out  32  PC of `instr_ID`.
- `valid_ID`  out  1  `instr_ID` is a real instruction.

## Operation
Registers:
- `pc`: next address to request. `imem_addr = pc` always.
- `pc_pend`: address of the outstanding request.
- Hold buffer: `hold_instr`, `hold_pc`.
- State: FETCH, WAIT, HOLD, DISCARD.

Request acceptance (any state that drives `imem_req`): `pc <= pc+4` and `pc_pend <= pc`. Arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.

`imem_req` is 1 in FETCH, and in WAIT when `imem_valid & ~stall & ~PCSel`. In all other cases it is 0.

State behaviour:
- FETCH: on acceptance, go to WAIT.
- WAIT with `imem_valid`:
  - `~stall`: IF/ID <= {`imem_rdata`, `pc_pend`, 1}. If the back-to-back request is also accepted, stay in WAIT; otherwise go to FETCH.
  - `stall`: the buffer captures {`imem_rdata`, `pc_pend`}; go to HOLD.
- HOLD: while `stall`, stay. On `~stall`, IF/ID <= {buffer, 1}; go to FETCH.
- DISCARD: `imem_req`=0. On `imem_valid`, drop the data and go to FETCH.

Redirect (`PCSel`=1) has the highest priority for `pc`: `pc <= {br_target[31:2],2'b00}`. It overrides the request increment.
- FETCH, request not accepted this cycle: stay in FETCH.
- FETCH, request accepted this cycle: go to DISCARD.
- WAIT without `imem_valid`: go to DISCARD.
- WAIT with `imem_valid`: drop the response and go to FETCH.
- HOLD: drop the buffer and go to FETCH.
- DISCARD: stay in DISCARD. The single outstanding response is still dropped.

IF/ID register priority is `flush_ID` > `stall` > load.
- `flush_ID`: `instr_ID <= NOP_INSTR`, `valid_ID <= 0`, `pc_ID` holds.
- `stall` without flush: all IF/ID outputs hold.
- `flush_ID` with `stall`: the register still flushes.
- A response loaded in the same cycle as `flush_ID` or `PCSel` is dropped, not written.

## Timing
- Reset (asynchronous, immediate):
  - `pc`=`RESET_PC`, state=FETCH.
  - `instr_ID`=`NOP_INSTR`, `pc_ID`=`RESET_PC`, `valid_ID`=0.
  - Buffer cleared.
  - `imem_req`=1 from the first cycle after deassertion.
  - Reset while WAIT or DISCARD abandons the outstanding request; the memory side must be reset together with this block.
- Latency: a response accepted in cycle N appears on `instr_ID` in cycle N+1.
- Throughput: with `imem_ready`=1 and `imem_valid` one cycle after acceptance, one instruction per cycle after the first request. First valid `instr_ID` is 2 cycles after reset release.
- Redirect: the new address is on `imem_addr` in the cycle after `PCSel` (FETCH state) or after the stale response drains (DISCARD).
- HOLD release: one bubble cycle, then a new request.

## Test plan
- Reset release, memory with `imem_ready`=1 and 1-cycle response: `imem_addr` = 0, 4, 8 on consecutive cycles; `pc_ID` = 0, 4, 8 with `valid_ID`=1 from cycle 2; before that, `instr_ID`=0x00000013 and `valid_ID`=0.
- `stall`=1 for 3 cycles while the response for 0x8 arrives: IF/ID holds the 0x4 entry; state HOLD; after release `pc_ID`=0x8, then a request for 0xC the next cycle; no instruction lost or duplicated.
- Memory with 3-cycle response latency; `PCSel`=1, `br_target`=0x100 while waiting on 0x4: the 0x4 response is discarded; next `imem_addr`=0x100; `pc_ID` never shows 0x4.
- `PCSel` in the same cycle as `imem_valid` in WAIT: response dropped; request for the target issued the next cycle; `valid_ID` unaffected by the dropped word.
- `flush_ID`=1 and `stall`=1 together: `instr_ID`=0x00000013, `valid_ID`=0, `pc_ID` unchanged.
- `rst_n` pulled low mid-WAIT, asynchronously between edges: outputs go to reset values immediately; after release, fetch restarts at `RESET_PC`.
